// File: rtl/text_console_controller_pkg.sv
// Shared text-console constants: buffer geometry, control characters, sequencer states.
package text_console_controller_pkg;

    localparam int GPU_TEXT_COLUMNS       = 80;
    localparam int GPU_TEXT_ROWS          = 30;
    localparam int GPU_TEXT_BUFFER_LENGTH = GPU_TEXT_COLUMNS * GPU_TEXT_ROWS;

    localparam logic [6:0] CHAR_SPACE = 7'h20;
    localparam logic [6:0] CHAR_LF    = 7'h0A;
    localparam logic [6:0] CHAR_CR    = 7'h0D;
    localparam logic [6:0] CHAR_BS    = 7'h08;
    localparam logic [6:0] CHAR_FF    = 7'h0C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUT,
        ST_CLEAR,
        ST_SCROLL_RD,
        ST_SCROLL_WR,
        ST_SCROLL_BLANK
    } state_t;

    function automatic logic is_printable(input logic [6:0] c);
        return (c >= 7'h20) && (c <= 7'h7E);
    endfunction

endpackage

// File: rtl/text_console_controller.sv
// Purpose: turns a CPU character/control byte stream into text-RAM port A writes, tracks cursor, runs clear/scroll.
// Latency: byte accepted at T, its RAM write is on port A at T+1; clear takes N cycles, scroll 2*(ROWS-1)*COLUMNS+COLUMNS.
// Backpressure: cmd_ready low in every non-IDLE state (and the cycle after a transfer); optional TEXT_CONSOLE_BOOT_CLEAR_EN clears after reset.
module text_console_controller
    import text_console_controller_pkg::*;
#(
    parameter int COLUMNS = GPU_TEXT_COLUMNS,
    parameter int ROWS    = GPU_TEXT_ROWS,
    parameter int AW      = $clog2(COLUMNS * ROWS),
    parameter int XW      = $clog2(COLUMNS),
    parameter int YW      = $clog2(ROWS)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [6:0]    cmd_char,
    output logic [AW-1:0] ram_address,
    output logic [6:0]    ram_data_out,
    output logic          ram_write_enable,
    input  logic [6:0]    ram_data_in,
    output logic [XW-1:0] cursor_x,
    output logic [YW-1:0] cursor_y,
    output logic          busy
);

    localparam logic [AW-1:0] LAST_CELL  = AW'(COLUMNS * ROWS - 1);
    localparam logic [AW-1:0] LAST_ROW   = AW'((ROWS - 1) * COLUMNS);
    localparam logic [AW-1:0] SCROLL_END = AW'((ROWS - 1) * COLUMNS - 1);
    localparam logic [AW-1:0] COLS_A     = AW'(COLUMNS);
    localparam logic [XW-1:0] X_MAX      = XW'(COLUMNS - 1);
    localparam logic [YW-1:0] Y_MAX      = YW'(ROWS - 1);

`ifdef TEXT_CONSOLE_BOOT_CLEAR_EN
    localparam state_t RESET_STATE = ST_CLEAR;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t        state, state_d;
    logic          ready_d, we_d, busy_d, pend_d, scroll_pend;
    logic [AW-1:0] addr_d, curs_addr, curs_d;
    logic [6:0]    data_q, data_d;
    logic [XW-1:0] x_d;
    logic [YW-1:0] y_d;

    // Scroll write data comes straight from the RAM's registered read port.
    assign ram_data_out = (state == ST_SCROLL_WR) ? ram_data_in : data_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= RESET_STATE;
            cmd_ready        <= 1'b0;
            ram_write_enable <= 1'b0;
            ram_address      <= '0;
            data_q           <= '0;
            cursor_x         <= '0;
            cursor_y         <= '0;
            curs_addr        <= '0;
            busy             <= 1'b0;
            scroll_pend      <= 1'b0;
        end else begin
            state            <= state_d;
            cmd_ready        <= ready_d;
            ram_write_enable <= we_d;
            ram_address      <= addr_d;
            data_q           <= data_d;
            cursor_x         <= x_d;
            cursor_y         <= y_d;
            curs_addr        <= curs_d;
            busy             <= busy_d;
            scroll_pend      <= pend_d;
        end
    end

    always_comb begin
        state_d = state;
        ready_d = 1'b0;
        we_d    = 1'b0;
        busy_d  = busy;
        pend_d  = scroll_pend;
        addr_d  = ram_address;
        data_d  = data_q;
        x_d     = cursor_x;
        y_d     = cursor_y;
        curs_d  = curs_addr;
        case (state)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    ready_d = 1'b0;
                    if (is_printable(cmd_char)) begin
                        state_d = ST_PUT;
                        we_d    = 1'b1;
                        addr_d  = curs_addr;
                        data_d  = cmd_char;
                        if (cursor_x == X_MAX) begin
                            x_d = '0;
                            if (cursor_y == Y_MAX) begin
                                curs_d = LAST_ROW;
                                pend_d = 1'b1;
                            end else begin
                                y_d    = cursor_y + 1'b1;
                                curs_d = curs_addr + 1'b1;
                            end
                        end else begin
                            x_d    = cursor_x + 1'b1;
                            curs_d = curs_addr + 1'b1;
                        end
                    end else begin
                        case (cmd_char)
                            CHAR_CR: begin
                                x_d    = '0;
                                curs_d = curs_addr - AW'(cursor_x);
                            end
                            CHAR_LF: begin
                                x_d = '0;
                                if (cursor_y == Y_MAX) begin
                                    curs_d  = curs_addr - AW'(cursor_x);
                                    state_d = ST_SCROLL_RD;
                                    busy_d  = 1'b1;
                                    addr_d  = COLS_A;
                                end else begin
                                    y_d    = cursor_y + 1'b1;
                                    curs_d = curs_addr - AW'(cursor_x) + COLS_A;
                                end
                            end
                            CHAR_BS: begin
                                if (cursor_x != '0) begin
                                    x_d     = cursor_x - 1'b1;
                                    curs_d  = curs_addr - 1'b1;
                                    state_d = ST_PUT;
                                    we_d    = 1'b1;
                                    addr_d  = curs_addr - 1'b1;
                                    data_d  = CHAR_SPACE;
                                end
                            end
                            CHAR_FF: begin
                                x_d     = '0;
                                y_d     = '0;
                                curs_d  = '0;
                                state_d = ST_CLEAR;
                                busy_d  = 1'b1;
                                we_d    = 1'b1;
                                addr_d  = '0;
                                data_d  = CHAR_SPACE;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_PUT: begin
                if (scroll_pend) begin
                    pend_d  = 1'b0;
                    state_d = ST_SCROLL_RD;
                    busy_d  = 1'b1;
                    addr_d  = COLS_A;
                end else begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end
            end
            ST_CLEAR: begin
                // Not yet busy only when arriving straight from reset (boot clear).
                if (!busy) begin
                    busy_d = 1'b1;
                    we_d   = 1'b1;
                    addr_d = '0;
                    data_d = CHAR_SPACE;
                end else if (ram_address == LAST_CELL) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    we_d   = 1'b1;
                    addr_d = ram_address + 1'b1;
                end
            end
            ST_SCROLL_RD: begin
                state_d = ST_SCROLL_WR;
                we_d    = 1'b1;
                addr_d  = ram_address - COLS_A;
            end
            ST_SCROLL_WR: begin
                if (ram_address == SCROLL_END) begin
                    state_d = ST_SCROLL_BLANK;
                    we_d    = 1'b1;
                    addr_d  = LAST_ROW;
                    data_d  = CHAR_SPACE;
                end else begin
                    state_d = ST_SCROLL_RD;
                    addr_d  = ram_address + COLS_A + 1'b1;
                end
            end
            ST_SCROLL_BLANK: begin
                if (ram_address == LAST_CELL) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    we_d   = 1'b1;
                    addr_d = ram_address + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_text_console_controller.sv
// Directed bench for text_console_controller with a behavioural port-A RAM and a backdoor preload port.
module tb_text_console_controller;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_char;
    logic [11:0] ram_address;
    logic [6:0]  ram_data_out;
    logic        ram_write_enable;
    logic [6:0]  ram_data_in;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int nrdy_cnt = 0;
    int busy_cnt = 0;

    logic [6:0]  mem [0:2399];
    logic        fill_en;
    logic [11:0] fill_addr;
    logic [6:0]  fill_dat;

    always #5 clock = ~clock;

    text_console_controller dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_char         (cmd_char),
        .ram_address      (ram_address),
        .ram_data_out     (ram_data_out),
        .ram_write_enable (ram_write_enable),
        .ram_data_in      (ram_data_in),
        .cursor_x         (cursor_x),
        .cursor_y         (cursor_y),
        .busy             (busy)
    );

    always @(posedge clock) begin
        if (fill_en) begin
            mem[fill_addr] <= fill_dat;
        end else if (ram_write_enable) begin
            mem[ram_address] <= ram_data_out;
            ram_data_in      <= ram_data_out;
        end else begin
            ram_data_in <= mem[ram_address];
        end
    end

    always @(negedge clock) begin
        we_cnt   <= we_cnt + int'(ram_write_enable);
        nrdy_cnt <= nrdy_cnt + int'(!cmd_ready);
        busy_cnt <= busy_cnt + int'(busy);
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n;
        n = 0;
        @(negedge clock);
        while (!(cmd_ready && !busy) && n < limit) begin
            @(negedge clock);
            n++;
        end
        check(tag, int'(cmd_ready && !busy), 1);
    endtask

    task automatic send(input logic [6:0] c);
        int n;
        n = 0;
        @(negedge clock);
        while (!cmd_ready && n < 10000) begin
            @(negedge clock);
            n++;
        end
        if (!cmd_ready) check("send_ready_timeout", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_char  = c;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic fill_cell(input int a, input logic [6:0] d);
        @(negedge clock);
        fill_en   = 1'b1;
        fill_addr = 12'(a);
        fill_dat  = d;
    endtask

    task automatic check_cursor(input string tag, input int x, input int y);
        check({tag, "_x"}, int'(cursor_x), x);
        check({tag, "_y"}, int'(cursor_y), y);
    endtask

    initial begin
        int we0, nr0, b0, bad;
        logic [6:0] boot_val;
`ifdef TEXT_CONSOLE_BOOT_CLEAR_EN
        boot_val = 7'h20;
`else
        boot_val = 7'h2E;
`endif
        cmd_valid = 1'b0;
        cmd_char  = 7'h00;
        fill_en   = 1'b0;
        fill_addr = '0;
        fill_dat  = '0;
        reset_n   = 1'b1;
        #1 reset_n = 1'b0;

        // Boot screen preload while held in reset.
        for (int i = 0; i < 2400; i++) fill_cell(i, 7'h2E);
        @(negedge clock);
        fill_en = 1'b0;

        check("rst_cmd_ready", int'(cmd_ready), 0);
        check("rst_we", int'(ram_write_enable), 0);
        check("rst_addr", int'(ram_address), 0);
        check("rst_data", int'(ram_data_out), 0);
        check("rst_cursor_x", int'(cursor_x), 0);
        check("rst_cursor_y", int'(cursor_y), 0);
        check("rst_busy", int'(busy), 0);

        @(negedge clock);
        reset_n = 1'b1;
        wait_idle("boot_idle", 3000);
        check("boot_screen", int'(mem[1234]), int'(boot_val));

        // Two printable bytes.
        we0 = we_cnt; nr0 = nrdy_cnt;
        send(7'h41);
        wait_idle("a_idle", 20);
        check("a_we_pulses", we_cnt - we0, 1);
        check("a_ready_low", nrdy_cnt - nr0, 1);
        we0 = we_cnt; nr0 = nrdy_cnt;
        send(7'h42);
        wait_idle("b_idle", 20);
        check("b_we_pulses", we_cnt - we0, 1);
        check("b_ready_low", nrdy_cnt - nr0, 1);
        check("ram0", int'(mem[0]), 'h41);
        check("ram1", int'(mem[1]), 'h42);
        check_cursor("ab_cursor", 2, 0);

        // Full row of 'x' with wrap to row 1.
        send(7'h0D);
        for (int i = 0; i < 80; i++) send(7'h78);
        wait_idle("row_idle", 20);
        bad = 0;
        for (int i = 0; i < 80; i++) if (mem[i] !== 7'h78) bad++;
        check("row0_x_bad", bad, 0);
        check("row1_untouched", int'(mem[80]), int'(boot_val));
        check_cursor("row_wrap", 0, 1);

        // CR / BS behaviour on row 3.
        send(7'h0A); send(7'h0A);
        for (int i = 0; i < 5; i++) send(7'h71);
        wait_idle("q_idle", 20);
        check_cursor("pre_cr", 5, 3);
        we0 = we_cnt;
        send(7'h0D);
        wait_idle("cr_idle", 20);
        check_cursor("cr", 0, 3);
        check("cr_no_write", we_cnt - we0, 0);
        send(7'h08);
        wait_idle("bs0_idle", 20);
        check_cursor("bs_at_0", 0, 3);
        check("bs0_no_write", we_cnt - we0, 0);
        for (int i = 0; i < 4; i++) send(7'h7A);
        send(7'h08);
        wait_idle("bs_idle", 20);
        check("bs_blank", int'(mem[243]), 'h20);
        check("bs_keep", int'(mem[242]), 'h7A);
        check_cursor("bs", 3, 3);
        send(7'h77);
        wait_idle("w_idle", 20);
        check("bs_then_w", int'(mem[243]), 'h77);
        we0 = we_cnt;
        send(7'h7F); send(7'h01);
        wait_idle("ign_idle", 20);
        check("ignored_no_write", we_cnt - we0, 0);
        check_cursor("ignored", 4, 3);

        // Form feed.
        b0 = busy_cnt; nr0 = nrdy_cnt;
        send(7'h0C);
        wait_idle("ff_idle", 3000);
        check("ff_busy_cycles", busy_cnt - b0, 2400);
        check("ff_ready_low", nrdy_cnt - nr0, 2400);
        bad = 0;
        for (int i = 0; i < 2400; i++) if (mem[i] !== 7'h20) bad++;
        check("ff_all_space_bad", bad, 0);
        check_cursor("ff", 0, 0);

        // Scroll on LF at the last row.
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++) fill_cell(r * 80 + c, 7'(8'h30 + r));
        @(negedge clock);
        fill_en = 1'b0;
        for (int i = 0; i < 29; i++) send(7'h0A);
        wait_idle("lf_idle", 20);
        check_cursor("at_row29", 0, 29);
        b0 = busy_cnt;
        send(7'h0A);
        wait_idle("scroll_idle", 6000);
        check("scroll_busy_cycles", busy_cnt - b0, 4720);
        bad = 0;
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++)
                if (mem[r * 80 + c] !== ((r < 29) ? 7'(8'h31 + r) : 7'h20)) bad++;
        check("scroll_content_bad", bad, 0);
        check_cursor("scroll", 0, 29);

        // Wrap off the last row triggers scroll after the write.
        b0 = busy_cnt;
        for (int i = 0; i < 80; i++) send(7'h6B);
        wait_idle("wrap_scroll_idle", 6000);
        check("wrap_scroll_busy", busy_cnt - b0, 4720);
        bad = 0;
        for (int c = 0; c < 80; c++) begin
            if (mem[28 * 80 + c] !== 7'h6B) bad++;
            if (mem[29 * 80 + c] !== 7'h20) bad++;
        end
        check("wrap_scroll_rows_bad", bad, 0);
        check("wrap_scroll_row27", int'(mem[27 * 80 + 5]), 'h4D);
        check_cursor("wrap_scroll", 0, 29);

        // Reset in the middle of a scroll.
        send(7'h0A);
        repeat (100) @(negedge clock);
        check("mid_scroll_busy", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_we", int'(ram_write_enable), 0);
        check("mid_rst_addr", int'(ram_address), 0);
        check("mid_rst_data", int'(ram_data_out), 0);
        check("mid_rst_ready", int'(cmd_ready), 0);
        check("mid_rst_cursor_y", int'(cursor_y), 0);
        check("mid_rst_cursor_x", int'(cursor_x), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        wait_idle("post_rst_idle", 3000);
        send(7'h43);
        wait_idle("post_rst_c_idle", 20);
        check("post_rst_ram0", int'(mem[0]), 'h43);
        check_cursor("post_rst", 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
